rawp_port_arbiter: RTL

- Shares the single raw (non-Wishbone) port of the dual-port DMA RAM between NUM_REQ local requesters, for example Ethernet RX writer, TX reader and checksum engine.
- Round-robin arbitration with burst locking.
- Address range check against the RAM size.
- Per-beat accept/read-valid/error handshake that matches the RAM's one-cycle registered read latency.
- Sits between the peripheral DMA engines and the RAM's rawp_* port, in the rawp_clk domain.

---
 rtl/rawp_port_arbiter_if.sv | 27 ++
 rtl/rawp_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rawp_port_arbiter_if.sv
// Requester-side bundle of the raw DMA RAM port arbiter: per-requester beat
// signals in, grant/accept/response signals out.
interface rawp_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            last_i;
  logic [NUM_REQ-1:0]            we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] adr_i;
  logic [NUM_REQ*32-1:0]         dat_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            acc_o;
  logic [NUM_REQ-1:0]            rdv_o;
  logic [NUM_REQ-1:0]            err_o;
  logic [31:0]                   rdat_o;

  modport master (
    output req_i, last_i, we_i, adr_i, dat_i,
    input  gnt_o, acc_o, rdv_o, err_o, rdat_o
  );

  modport slave (
    input  req_i, last_i, we_i, adr_i, dat_i,
    output gnt_o, acc_o, rdv_o, err_o, rdat_o
  );
endinterface

// File: rtl/rawp_port_arbiter.sv
// Round-robin arbiter sharing the single raw port of the DMA RAM between
// NUM_REQ requesters, with burst locking, range checking and per-beat handshake.
module rawp_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BYTES  = 4096,
  parameter int MAX_BURST  = 16
) (
  input  logic                  rawp_clk,
  input  logic                  rawp_rst,
  rawp_port_arbiter_if.slave    req_if,
  output logic [ADDR_WIDTH-1:0] ram_adr_o,
  output logic [31:0]           ram_dat_o,
  output logic                  ram_we_o,
  input  logic [31:0]           ram_dat_i
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam bit                  ALL_IN_RANGE = (MEM_BYTES >> ADDR_WIDTH) != 0;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT    = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [CW-1:0]       CNT_LAST     = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0]       OWNER_MAX    = OW'(NUM_REQ - 1);
  localparam logic [OW:0]         NUM_REQ_W    = (OW+1)'(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      burstCnt_q, burstCnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rdv_q, rdv_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic                  ownReq, ownWe, ownLast, inRange;
  logic [ADDR_WIDTH-1:0] ownAdr;
  logic [31:0]           ownDat;

  logic [NUM_REQ-1:0] reqRot;
  logic               anyReq;
  logic [OW-1:0]      offset, pick;
  logic [OW:0]        pickSum;

  logic [NUM_REQ-1:0]    accVec;
  logic                  ramWe, relBurst;
  logic [ADDR_WIDTH-1:0] ramAdr;
  logic [31:0]           ramDat;

  // Select the current owner's beat signals.
  always_comb begin
    ownReq  = 1'b0;
    ownWe   = 1'b0;
    ownLast = 1'b0;
    ownAdr  = '0;
    ownDat  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == OW'(k)) begin
        ownReq  = req_if.req_i[k];
        ownWe   = req_if.we_i[k];
        ownLast = req_if.last_i[k];
        ownAdr  = req_if.adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        ownDat  = req_if.dat_i[k*32 +: 32];
      end
    end
  end

  assign inRange = ALL_IN_RANGE || ({1'b0, ownAdr} < MEM_LIMIT);

  // Rotate requests so the search starts at ptr; the lowest set bit wins.
  always_comb begin
    reqRot = NUM_REQ'({req_if.req_i, req_if.req_i} >> ptr_q);
    anyReq = 1'b0;
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        anyReq = 1'b1;
        offset = OW'(i);
      end
    end
    pickSum = {1'b0, ptr_q} + {1'b0, offset};
    if (pickSum >= NUM_REQ_W) begin
      pickSum = pickSum - NUM_REQ_W;
    end
    pick = pickSum[OW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    burstCnt_d = burstCnt_q;
    gnt_d      = gnt_q;
    rdv_d      = '0;
    err_d      = '0;
    accVec     = '0;
    ramWe      = 1'b0;
    ramAdr     = '0;
    ramDat     = '0;
    relBurst   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d    = BUSY;
          owner_d    = pick;
          burstCnt_d = '0;
          for (int k = 0; k < NUM_REQ; k++) begin
            gnt_d[k] = (pick == OW'(k));
          end
        end
      end
      BUSY: begin
        ramAdr = ownAdr;
        ramDat = ownDat;
        if (ownReq) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            accVec[k] = (owner_q == OW'(k));
          end
          // Out-of-range writes are turned into an error, never a RAM write.
          ramWe = ownWe & inRange;
          if (!inRange) begin
            err_d = accVec;
          end else if (!ownWe) begin
            rdv_d = accVec;
          end
          if (ownLast || (burstCnt_q == CNT_LAST)) begin
            relBurst = 1'b1;
          end else if (burstCnt_q != '1) begin
            burstCnt_d = burstCnt_q + 1'b1;
          end
        end else begin
          relBurst = 1'b1;
        end
        if (relBurst) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (owner_q == OWNER_MAX) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rawp_clk) begin
    if (rawp_rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      burstCnt_q <= '0;
      gnt_q      <= '0;
      rdv_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      burstCnt_q <= burstCnt_d;
      gnt_q      <= gnt_d;
      rdv_q      <= rdv_d;
      err_q      <= err_d;
    end
  end

  // Combinational outputs are held quiet while reset is asserted.
  assign req_if.acc_o  = rawp_rst ? '0 : accVec;
  assign ram_we_o      = ramWe & ~rawp_rst;
  assign ram_adr_o     = rawp_rst ? '0 : ramAdr;
  assign ram_dat_o     = rawp_rst ? '0 : ramDat;
  assign req_if.gnt_o  = gnt_q;
  assign req_if.rdv_o  = rdv_q;
  assign req_if.err_o  = err_q;
  assign req_if.rdat_o = ram_dat_i;

endmodule
